// File: rtl/block_load_ctrl_352_if.sv
// rtl/block_load_ctrl_352_if.sv - word stream from the host into the block load controller
interface block_load_ctrl_352_if #(
  parameter int WORD_W = 32
);
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/block_load_ctrl_352.sv
// rtl/block_load_ctrl_352.sv - assembles one 352-bit block, commits it to memory, starts the hash core
module block_load_ctrl_352 #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 11,
  parameter int CNT_W     = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  block_load_ctrl_352_if.slave   src,
  output logic                   mem_write_en,
  output logic [351:0]           mem_block_in,
  output logic                   core_start,
  input  logic                   core_done,
  output logic                   busy,
  output logic                   err_len,
  output logic [CNT_W-1:0]       blk_cnt
);
  localparam int BLK_W = WORD_W * NUM_WORDS;
  localparam int WC_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WC_W-1:0] LAST_IDX = WC_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {S_LOAD, S_DRAIN, S_COMMIT, S_START, S_WAIT} state_t;

  state_t           state;
  logic [WC_W-1:0]  wcnt;
  logic [BLK_W-1:0] asm_reg;
  logic             xfer;

  // Ready is decoded from state and gated by reset so it drops during RST itself.
  assign src.in_ready = !RST && (state == S_LOAD || state == S_DRAIN);
  assign xfer         = src.in_valid && src.in_ready;
  assign mem_block_in = asm_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_LOAD;
      wcnt         <= '0;
      asm_reg      <= '0;
      blk_cnt      <= '0;
      mem_write_en <= 1'b0;
      core_start   <= 1'b0;
      err_len      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      mem_write_en <= 1'b0;
      core_start   <= 1'b0;
      err_len      <= 1'b0;
      case (state)
        S_LOAD: begin
          if (xfer) begin
            // First word of the block lands in the most significant slot.
            for (int k = 0; k < NUM_WORDS; k++) begin
              if (wcnt == WC_W'(k)) asm_reg[BLK_W-1-WORD_W*k -: WORD_W] <= src.in_data;
            end
            if (wcnt == LAST_IDX) begin
              wcnt <= '0;
              if (src.in_last) begin
                state        <= S_COMMIT;
                mem_write_en <= 1'b1;
                busy         <= 1'b1;
              end else begin
                err_len <= 1'b1;
                state   <= S_DRAIN;
              end
            end else if (src.in_last) begin
              err_len <= 1'b1;
              wcnt    <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (xfer && src.in_last) state <= S_LOAD;
        end
        S_COMMIT: begin
          state      <= S_START;
          core_start <= 1'b1;
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            blk_cnt <= blk_cnt + 1'b1;
            state   <= S_LOAD;
            busy    <= 1'b0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_block_load_ctrl_352.sv
// tb/tb_block_load_ctrl_352.sv - randomized self-checking bench for block_load_ctrl_352
module tb_block_load_ctrl_352;
  localparam int WORD_W = 32;
  localparam int NUM_WORDS = 11;
  localparam int CNT_W = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic core_done = 1'b0;
  logic mem_write_en, core_start, busy, err_len;
  logic [351:0] mem_block_in;
  logic [CNT_W-1:0] blk_cnt;

  block_load_ctrl_352_if #(.WORD_W(WORD_W)) src_if ();

  block_load_ctrl_352 #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .src(src_if.slave),
    .mem_write_en(mem_write_en), .mem_block_in(mem_block_in),
    .core_start(core_start), .core_done(core_done),
    .busy(busy), .err_len(err_len), .blk_cnt(blk_cnt)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  logic [WORD_W-1:0] blk_words [16];
  logic [CNT_W-1:0] exp_blk = '0;

  always @(negedge CLK) begin
    if (mem_write_en === 1'b1) wr_cnt <= wr_cnt + 1;
    if (core_start === 1'b1) start_cnt <= start_cnt + 1;
    if (err_len === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [351:0] pack_block();
    logic [351:0] r = '0;
    for (int i = 0; i < NUM_WORDS; i++) r = {r[351-WORD_W:0], blk_words[i]};
    return r;
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) blk_words[i] = $urandom;
  endtask

  task automatic push_word(input logic [WORD_W-1:0] d, input logic last, input int gap);
    int t = 0;
    src_if.in_valid = 1'b0;
    for (int g = 0; g < gap; g++) step();
    src_if.in_valid = 1'b1;
    src_if.in_data = d;
    src_if.in_last = last;
    while (src_if.in_ready !== 1'b1 && t < 50) begin step(); t++; end
    nvec++;
    if (t >= 50) begin nerr++; $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", src_if.in_ready, t); end
    step();
    src_if.in_valid = 1'b0;
    src_if.in_last = 1'b0;
  endtask

  task automatic send_block(input int n, input int gapmode);
    for (int i = 0; i < n; i++)
      push_word(blk_words[i], (i == n - 1), gapmode == 0 ? 0 : gapmode == 1 ? 1 : $urandom_range(0, 2));
  endtask

  // Called right after the last word's transfer edge; follows commit, start, wait and done.
  task automatic check_commit(input string nm);
    logic [351:0] exp = pack_block();
    int d = $urandom_range(0, 3);
    nvec += 4;
    if (mem_write_en !== 1'b1) begin nerr++; $display("FAIL %s wr_latency: mem_write_en=%b required 1", nm, mem_write_en); end
    if (mem_block_in !== exp) begin nerr++; $display("FAIL %s block: got %h required %h", nm, mem_block_in, exp); end
    if (src_if.in_ready !== 1'b0) begin nerr++; $display("FAIL %s ready_commit: in_ready=%b required 0", nm, src_if.in_ready); end
    if (busy !== 1'b1) begin nerr++; $display("FAIL %s busy: got %b required 1", nm, busy); end
    step();
    nvec += 2;
    if (core_start !== 1'b1) begin nerr++; $display("FAIL %s start_latency: core_start=%b required 1", nm, core_start); end
    if (mem_write_en !== 1'b0) begin nerr++; $display("FAIL %s wr_pulse: mem_write_en=%b required 0", nm, mem_write_en); end
    step();
    nvec++;
    if (core_start !== 1'b0) begin nerr++; $display("FAIL %s start_pulse: core_start=%b required 0", nm, core_start); end
    for (int i = 0; i < d; i++) begin
      nvec++;
      if (src_if.in_ready !== 1'b0) begin nerr++; $display("FAIL %s ready_wait: in_ready=%b required 0", nm, src_if.in_ready); end
      step();
    end
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    exp_blk = exp_blk + 1'b1;
    nvec += 4;
    if (blk_cnt !== exp_blk) begin nerr++; $display("FAIL %s blk_cnt: got %0d required %0d", nm, blk_cnt, exp_blk); end
    if (src_if.in_ready !== 1'b1) begin nerr++; $display("FAIL %s ready_after_done: in_ready=%b required 1", nm, src_if.in_ready); end
    if (busy !== 1'b0) begin nerr++; $display("FAIL %s busy_after_done: got %b required 0", nm, busy); end
    if (mem_block_in !== exp) begin nerr++; $display("FAIL %s block_held: got %h required %h", nm, mem_block_in, exp); end
  endtask

  task automatic check_dropped(input string nm, input int wr0, input int st0, input int er0);
    step();
    step();
    nvec += 5;
    if (err_cnt !== er0 + 1) begin nerr++; $display("FAIL %s err_pulses: got %0d required %0d", nm, err_cnt - er0, 1); end
    if (wr_cnt !== wr0) begin nerr++; $display("FAIL %s no_write: got %0d writes required 0", nm, wr_cnt - wr0); end
    if (start_cnt !== st0) begin nerr++; $display("FAIL %s no_start: got %0d starts required 0", nm, start_cnt - st0); end
    if (src_if.in_ready !== 1'b1) begin nerr++; $display("FAIL %s ready_after_drop: in_ready=%b required 1", nm, src_if.in_ready); end
    if (blk_cnt !== exp_blk) begin nerr++; $display("FAIL %s blk_cnt_drop: got %0d required %0d", nm, blk_cnt, exp_blk); end
  endtask

  task automatic check_reset_outputs(input string nm);
    nvec += 6;
    if (mem_write_en !== 1'b0) begin nerr++; $display("FAIL %s rst_wr: got %b required 0", nm, mem_write_en); end
    if (core_start !== 1'b0) begin nerr++; $display("FAIL %s rst_start: got %b required 0", nm, core_start); end
    if (err_len !== 1'b0) begin nerr++; $display("FAIL %s rst_err: got %b required 0", nm, err_len); end
    if (busy !== 1'b0) begin nerr++; $display("FAIL %s rst_busy: got %b required 0", nm, busy); end
    if (blk_cnt !== '0) begin nerr++; $display("FAIL %s rst_blk_cnt: got %0d required 0", nm, blk_cnt); end
    if (mem_block_in !== '0) begin nerr++; $display("FAIL %s rst_block: got %h required 0", nm, mem_block_in); end
  endtask

  task automatic apply_reset(input string nm);
    RST = 1'b1;
    #0;
    nvec++;
    if (src_if.in_ready !== 1'b0) begin nerr++; $display("FAIL %s ready_in_rst: in_ready=%b required 0", nm, src_if.in_ready); end
    step();
    check_reset_outputs(nm);
    RST = 1'b0;
    #0;
    exp_blk = '0;
    nvec++;
    if (src_if.in_ready !== 1'b1) begin nerr++; $display("FAIL %s ready_after_rst: in_ready=%b required 1", nm, src_if.in_ready); end
  endtask

  task automatic test_reset();
    step();
    step();
    apply_reset("reset");
  endtask

  task automatic test_nominal();
    for (int i = 0; i < NUM_WORDS; i++) blk_words[i] = i;
    send_block(NUM_WORDS, 0);
    check_commit("nominal");
  endtask

  task automatic test_backpressure();
    fill_random(NUM_WORDS);
    send_block(NUM_WORDS, 1);
    check_commit("backpressure");
  endtask

  task automatic test_short();
    int wr0 = wr_cnt, st0 = start_cnt, er0 = err_cnt;
    fill_random(5);
    send_block(5, 0);
    nvec++;
    if (err_len !== 1'b1) begin nerr++; $display("FAIL short err_len: got %b required 1", err_len); end
    check_dropped("short", wr0, st0, er0);
    fill_random(NUM_WORDS);
    send_block(NUM_WORDS, 2);
    check_commit("after_short");
  endtask

  task automatic test_long();
    int wr0 = wr_cnt, st0 = start_cnt, er0 = err_cnt;
    fill_random(14);
    send_block(14, 0);
    check_dropped("long", wr0, st0, er0);
    fill_random(NUM_WORDS);
    send_block(NUM_WORDS, 0);
    check_commit("after_long");
  endtask

  task automatic test_reset_mid();
    fill_random(6);
    for (int i = 0; i < 6; i++) push_word(blk_words[i], 1'b0, 0);
    apply_reset("rst_mid_load");
    fill_random(NUM_WORDS);
    send_block(NUM_WORDS, 0);
    check_commit("after_rst_load");
    fill_random(NUM_WORDS);
    send_block(NUM_WORDS, 0);
    step();
    step();
    apply_reset("rst_in_wait");
    fill_random(NUM_WORDS);
    send_block(NUM_WORDS, 2);
    check_commit("after_rst_wait");
  endtask

  task automatic test_done_ignored();
    fill_random(NUM_WORDS);
    core_done = 1'b1;
    send_block(NUM_WORDS, 2);
    core_done = 1'b0;
    nvec++;
    if (blk_cnt !== exp_blk) begin nerr++; $display("FAIL done_ignored: blk_cnt=%0d required %0d", blk_cnt, exp_blk); end
    check_commit("done_ignored");
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] start_val = exp_blk;
    for (int b = 0; b < (1 << CNT_W); b++) begin
      fill_random(NUM_WORDS);
      send_block(NUM_WORDS, 0);
      check_commit("wrap");
    end
    nvec++;
    if (blk_cnt !== start_val) begin nerr++; $display("FAIL wrap_total: blk_cnt=%0d required %0d", blk_cnt, start_val); end
  endtask

  task automatic test_random();
    for (int b = 0; b < 20; b++) begin
      int kind = $urandom_range(0, 2);
      int n = (kind == 0) ? NUM_WORDS : (kind == 1) ? $urandom_range(1, NUM_WORDS - 1) : $urandom_range(NUM_WORDS + 1, 15);
      int wr0 = wr_cnt, st0 = start_cnt, er0 = err_cnt;
      fill_random(n);
      send_block(n, 2);
      if (kind == 0) check_commit("random_good");
      else check_dropped("random_bad", wr0, st0, er0);
    end
  endtask

  initial begin
    src_if.in_valid = 1'b0;
    src_if.in_data = '0;
    src_if.in_last = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_short();
    test_long();
    test_reset_mid();
    test_done_ignored();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
